uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_pkg.sv | 30 +++
 rtl/uart_rx_edge_bit_cnt.sv | 51 +++++
 rtl/uart_rx_ctrl.sv | 143 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared FSM encoding and prescale constants for the UART receive controller.
package uart_rx_pkg;

  localparam int unsigned EDGE_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE
  } rx_state_e;

  localparam logic [EDGE_W-1:0] PRESCALE_2  = 6'd2;
  localparam logic [EDGE_W-1:0] PRESCALE_4  = 6'd4;
  localparam logic [EDGE_W-1:0] PRESCALE_8  = 6'd8;
  localparam logic [EDGE_W-1:0] PRESCALE_16 = 6'd16;
  localparam logic [EDGE_W-1:0] PRESCALE_32 = 6'd32;

  function automatic logic prescale_ok(input logic [EDGE_W-1:0] p);
    return p inside {PRESCALE_2, PRESCALE_4, PRESCALE_8, PRESCALE_16, PRESCALE_32};
  endfunction

  // States that occupy a full oversampled bit period on the line.
  function automatic logic in_bit_state(input rx_state_e s);
    return s inside {ST_START, ST_DATA, ST_PARITY, ST_STOP};
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample edge counter and data-bit counter for the UART receive controller.
module uart_rx_edge_bit_cnt
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BCW        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cnt_en,
  input  logic              bit_en,
  input  logic [EDGE_W-1:0] prescale,
  output logic [EDGE_W-1:0] edge_cnt,
  output logic              edge_last,
  output logic [BCW-1:0]    bit_cnt,
  output logic              bit_last
);

  logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;

  always_comb begin
    edge_last  = (edge_cnt_q == prescale - 6'd1);
    bit_last   = (bit_cnt_q == BCW'(DATA_WIDTH - 1));
    edge_cnt_d = '0;
    if (cnt_en && !edge_last) begin
      edge_cnt_d = edge_cnt_q + 6'd1;
    end
    bit_cnt_d = '0;
    if (bit_en) begin
      bit_cnt_d = bit_cnt_q;
      if (edge_last) begin
        bit_cnt_d = bit_last ? '0 : bit_cnt_q + BCW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign edge_cnt = edge_cnt_q;
  assign bit_cnt  = bit_cnt_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start/data/parity/stop sequencing with registered result pulses.
// Parity support is compiled in only when UART_RX_PARITY_EN is defined.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [EDGE_W-1:0]     prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  sampled_bit,
  output logic                  dat_samp_en,
  output logic [EDGE_W-1:0]     edge_cnt,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int unsigned BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  rx_state_e             state_q, state_d;
  rx_state_e             done_st_q, done_st_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic                  par_pend_q, par_pend_d;
  logic                  samp_en_q, samp_en_d;
  logic                  cnt_en, bit_en, edge_last, bit_last, par_on;
  logic [BCW-1:0]        bit_cnt;

`ifdef UART_RX_PARITY_EN
  assign par_on = PAR_EN;
`else
  logic unused_par;
  assign par_on     = 1'b0;
  assign unused_par = PAR_EN ^ PAR_TYP;
`endif

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    p_data_d     = p_data_q;
    par_pend_d   = par_pend_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!RX_IN && prescale_ok(prescale)) begin
          state_d    = ST_START;
          par_pend_d = 1'b0;
        end
      end
      ST_START:  if (edge_last) state_d = ST_DATA;
      ST_DATA:   if (edge_last && bit_last) state_d = par_on ? ST_PARITY : ST_STOP;
      ST_PARITY: if (edge_last) state_d = ST_STOP;
      ST_STOP:   if (edge_last) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // The sampler's vote for a bit lands one cycle after that bit ends, so
    // each bit is acted on here, keyed by the state it was received in.
    if (done_q) begin
      case (done_st_q)
        ST_START: if (sampled_bit) state_d = ST_IDLE;
        ST_DATA:  shift_d = (shift_q >> 1) | (DATA_WIDTH'(sampled_bit) << (DATA_WIDTH - 1));
`ifdef UART_RX_PARITY_EN
        ST_PARITY: par_pend_d = sampled_bit ^ (^shift_q) ^ PAR_TYP;
`endif
        ST_STOP: begin
          stp_err_d    = !sampled_bit;
          par_err_d    = par_pend_q;
          data_valid_d = sampled_bit && !par_pend_q;
          if (data_valid_d) p_data_d = shift_q;
        end
        default: ;
      endcase
    end

    done_d    = in_bit_state(state_q) && edge_last;
    done_st_d = state_q;
    cnt_en    = in_bit_state(state_q) && in_bit_state(state_d);
    bit_en    = (state_q == ST_DATA) && (state_d == ST_DATA);
    samp_en_d = in_bit_state(state_d);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= ST_IDLE;
      done_st_q    <= ST_IDLE;
      done_q       <= 1'b0;
      shift_q      <= '0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      par_pend_q   <= 1'b0;
      samp_en_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      done_st_q    <= done_st_d;
      done_q       <= done_d;
      shift_q      <= shift_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
      par_pend_q   <= par_pend_d;
      samp_en_q    <= samp_en_d;
    end
  end

  uart_rx_edge_bit_cnt #(
    .DATA_WIDTH(DATA_WIDTH),
    .BCW       (BCW)
  ) u_cnt (
    .clk      (CLK),
    .rst_n    (RST),
    .cnt_en   (cnt_en),
    .bit_en   (bit_en),
    .prescale (prescale),
    .edge_cnt (edge_cnt),
    .edge_last(edge_last),
    .bit_cnt  (bit_cnt),
    .bit_last (bit_last)
  );

  assign dat_samp_en = samp_en_q;
  assign P_DATA      = p_data_q;
  assign data_valid  = data_valid_q;
  assign par_err     = par_err_q;
  assign stp_err     = stp_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: frame table plus hand-written glitch and reset sequences.
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST, RX_IN, PAR_EN, PAR_TYP, sampled_bit;
  logic [5:0] prescale;
  logic       dat_samp_en, data_valid, par_err, stp_err;
  logic [5:0] edge_cnt;
  logic [7:0] P_DATA;

`ifdef UART_RX_PARITY_EN
  localparam bit PB = 1'b1;
`else
  localparam bit PB = 1'b0;
`endif

  always #5 CLK = ~CLK;

  uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .prescale(prescale),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .sampled_bit(sampled_bit),
    .dat_samp_en(dat_samp_en), .edge_cnt(edge_cnt), .P_DATA(P_DATA),
    .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
  );

  // Behavioural stand-in for the external sampler: takes the line mid-bit.
  logic samp_q;
  always @(posedge CLK or negedge RST) begin
    if (!RST) samp_q <= 1'b1;
    else if (dat_samp_en && edge_cnt == (prescale >> 1)) samp_q <= RX_IN;
  end
  assign sampled_bit = samp_q;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct packed {
    logic dv, pe, se;
    logic [7:0] pd;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  always @(negedge CLK) begin
    if (RST && (data_valid || par_err || stp_err)) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_pulse", 32'({data_valid, par_err, stp_err}), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("frame_result", 32'({data_valid, par_err, stp_err, P_DATA}), 32'(mon_e));
      end
    end
  end

  typedef struct packed {
    logic [5:0] ps;
    logic pen, ptyp;
    logic [7:0] d;
    logic pbit, stop;
    logic dv, pe, se;
    logic [7:0] pd;
  } row_t;
  row_t rows[8];

  task automatic wait_cycles(input int unsigned n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic set_ps(input logic [5:0] ps);
    if (prescale != ps) begin
      RX_IN = 1'b1;
      wait_cycles(3);
      prescale = ps;
    end
  endtask

  task automatic send_frame(input row_t r);
    int unsigned p;
    logic ok;
    exp_t e;
    p       = int'(prescale);
    ok      = 1'b0;
    PAR_EN  = r.pen;
    PAR_TYP = r.ptyp;
    RX_IN   = 1'b0;
    for (int i = 0; i < 4 && !ok; i++) begin
      @(posedge CLK);
      #1;
      ok = dat_samp_en;
    end
    chk("start_detect", 32'(ok), 32'd1);
    if (!ok) begin
      RX_IN = 1'b1;
      return;
    end
    chk("start_edge_cnt", 32'(edge_cnt), 32'd0);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    e.dv = r.dv; e.pe = r.pe; e.se = r.se; e.pd = r.pd;
    sb_q.push_back(e);
    wait_cycles(p);
    for (int i = 0; i < 8; i++) begin
      RX_IN = r.d[i];
      wait_cycles(p);
    end
    if (PB && r.pen) begin
      RX_IN = r.pbit;
      wait_cycles(p);
    end
    RX_IN = r.stop;
    wait_cycles(p);
    chk("done_samp_en", 32'(dat_samp_en), 32'd0);
    RX_IN = 1'b1;
  endtask

  initial begin
    row_t gr;
    //            ps     pen   ptyp  data   pbit  stop  dv               pe               se    pdata
    rows[0] = '{6'd8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1,            1'b0,            1'b0, 8'hA5};
    rows[1] = '{6'd32, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1,            1'b0,            1'b0, 8'h3C};
    rows[2] = '{6'd32, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, PB ? 1'b0 : 1'b1, PB ? 1'b1 : 1'b0, 1'b0, 8'h3C};
    rows[3] = '{6'd4,  1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0,            1'b0,            1'b1, 8'h3C};
    rows[4] = '{6'd2,  1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1,            1'b0,            1'b0, 8'h00};
    rows[5] = '{6'd2,  1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1,            1'b0,            1'b0, 8'hFF};
    rows[6] = '{6'd16, 1'b1, 1'b1, 8'h81, 1'b1, 1'b1, 1'b1,            1'b0,            1'b0, 8'h81};
    rows[7] = '{6'd8,  1'b1, 1'b1, 8'h7E, 1'b0, 1'b1, PB ? 1'b0 : 1'b1, PB ? 1'b1 : 1'b0, 1'b0,
                PB ? 8'h81 : 8'h7E};

    RST = 1'b0; RX_IN = 1'b1; prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    #12;
    chk("reset_outputs", 32'({dat_samp_en, edge_cnt, P_DATA, data_valid, par_err, stp_err}), 32'd0);
    @(negedge CLK) RST = 1'b1;
    wait_cycles(3);
    chk("idle_line_high", 32'({dat_samp_en, edge_cnt}), 32'd0);

    prescale = 6'd5;
    RX_IN = 1'b0;
    wait_cycles(5);
    chk("unsupported_ps_idle", 32'({dat_samp_en, edge_cnt}), 32'd0);
    RX_IN = 1'b1;
    wait_cycles(2);
    prescale = 6'd8;

    for (int i = 0; i < 8; i++) begin
      set_ps(rows[i].ps);
      send_frame(rows[i]);
    end
    wait_cycles(3);

    // Start glitch: line low for three cycles only.
    set_ps(6'd16);
    RX_IN = 1'b0;
    wait_cycles(3);
    chk("glitch_started", 32'(dat_samp_en), 32'd1);
    RX_IN = 1'b1;
    wait_cycles(20);
    chk("glitch_back_idle", 32'({dat_samp_en, edge_cnt}), 32'd0);
    chk("glitch_pdata_held", 32'(P_DATA), 32'(rows[7].pd));

    // Reset in the middle of data bit 1.
    set_ps(6'd8);
    RX_IN = 1'b0;
    wait_cycles(1);
    chk("abort_frame_started", 32'(dat_samp_en), 32'd1);
    wait_cycles(8);
    RX_IN = 1'b1;
    wait_cycles(12);
    RST = 1'b0;
    #1;
    chk("reset_mid_frame", 32'({dat_samp_en, edge_cnt, P_DATA, data_valid, par_err, stp_err}), 32'd0);
    wait_cycles(2);
    #2 RST = 1'b1;
    wait_cycles(20);
    chk("after_abort_idle", 32'({dat_samp_en, edge_cnt, P_DATA}), 32'd0);
    gr = '{6'd8, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC3};
    send_frame(gr);
    wait_cycles(3);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
